// File: rtl/connect4_board_if.sv
// Button/tick inputs and board/status outputs of the Connect Four game core.
// master = button/tick source side, slave = game core.
interface connect4_board_if #(
    parameter int COLS = 7,
    parameter int ROWS = 6
);
    logic                     tick;
    logic                     btn_left;
    logic                     btn_right;
    logic                     btn_drop;
    logic                     btn_pop;
    logic                     lock;
    logic [2*COLS*ROWS-1:0]   board;
    logic [2:0]               cursor;
    logic                     player;
    logic                     busy;
    logic                     fall_active;
    logic [2:0]               fall_row;
    logic                     move_done;
    logic                     move_err;
    logic [2:0]               last_col;
    logic [2:0]               last_row;

    modport master (
        output tick, btn_left, btn_right, btn_drop, btn_pop, lock,
        input  board, cursor, player, busy, fall_active, fall_row,
               move_done, move_err, last_col, last_row
    );

    modport slave (
        input  tick, btn_left, btn_right, btn_drop, btn_pop, lock,
        output board, cursor, player, busy, fall_active, fall_row,
               move_done, move_err, last_col, last_row
    );
endinterface

// File: rtl/connect4_board.sv
// Connect Four game core with pop-out: cursor, drop with tick-paced falling
// animation, pop of the mover's own bottom piece, and last-move reporting.
module connect4_board #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic            clk,
    input  logic            rst,
    connect4_board_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FALL = 2'd1;
    localparam logic [1:0] S_POP  = 2'd2;

    localparam logic [2:0] LAST_COL = 3'(COLS - 1);
    localparam logic [2:0] TOP_ROW  = 3'(ROWS - 1);

    logic [1:0] state_reg;
    logic [1:0] cell_reg [ROWS][COLS];
    logic [2:0] cursor_reg;
    logic [2:0] fall_row_reg;
    logic [2:0] last_col_reg;
    logic [2:0] last_row_reg;
    logic       player_reg;
    logic       busy_reg;
    logic       fall_active_reg;
    logic       move_done_reg;
    logic       move_err_reg;

    logic [1:0] player_code;
    logic [2:0] below_row;
    logic       top_full;
    logic       below_empty;
    logic       pop_legal;

    assign player_code = player_reg ? 2'b10 : 2'b01;
    assign below_row   = fall_row_reg - 3'd1;
    assign top_full    = (cell_reg[TOP_ROW][cursor_reg] != 2'b00);
    // below_row wraps when fall_row is 0, so the row test must guard the lookup
    assign below_empty = (fall_row_reg != 3'd0) && (cell_reg[below_row][cursor_reg] == 2'b00);
    assign pop_legal   = (cell_reg[0][cursor_reg] == player_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cursor_reg      <= '0;
            fall_row_reg    <= '0;
            last_col_reg    <= '0;
            last_row_reg    <= '0;
            player_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            fall_active_reg <= 1'b0;
            move_done_reg   <= 1'b0;
            move_err_reg    <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cell_reg[3'(r)][3'(c)] <= 2'b00;
                end
            end
        end else begin
            move_done_reg <= 1'b0;
            move_err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!bus.lock) begin
                        if (bus.btn_drop) begin
                            if (top_full) begin
                                move_err_reg <= 1'b1;
                            end else begin
                                state_reg       <= S_FALL;
                                fall_row_reg    <= TOP_ROW;
                                fall_active_reg <= 1'b1;
                                busy_reg        <= 1'b1;
                            end
                        end else if (bus.btn_pop) begin
                            if (pop_legal) begin
                                state_reg <= S_POP;
                                busy_reg  <= 1'b1;
                            end else begin
                                move_err_reg <= 1'b1;
                            end
                        end else if (bus.btn_left) begin
                            if (cursor_reg != 3'd0) cursor_reg <= cursor_reg - 3'd1;
                        end else if (bus.btn_right) begin
                            if (cursor_reg != LAST_COL) cursor_reg <= cursor_reg + 3'd1;
                        end
                    end
                end
                S_FALL: begin
                    if (bus.tick) begin
                        if (below_empty) begin
                            fall_row_reg <= below_row;
                        end else begin
                            cell_reg[fall_row_reg][cursor_reg] <= player_code;
                            last_col_reg    <= cursor_reg;
                            last_row_reg    <= fall_row_reg;
                            player_reg      <= ~player_reg;
                            move_done_reg   <= 1'b1;
                            fall_active_reg <= 1'b0;
                            busy_reg        <= 1'b0;
                            state_reg       <= S_IDLE;
                        end
                    end
                end
                S_POP: begin
                    if (bus.tick) begin
                        // whole column shifts down one row in a single step
                        for (int r = 0; r < ROWS - 1; r++) begin
                            cell_reg[3'(r)][cursor_reg] <= cell_reg[3'(r + 1)][cursor_reg];
                        end
                        cell_reg[TOP_ROW][cursor_reg] <= 2'b00;
                        last_col_reg  <= cursor_reg;
                        last_row_reg  <= 3'd0;
                        player_reg    <= ~player_reg;
                        move_done_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    wire [2*COLS*ROWS-1:0] board_flat;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            assign board_flat[2*(gi*COLS+gj) +: 2] = cell_reg[gi][gj];
        end
    end

    assign bus.board       = board_flat;
    assign bus.cursor      = cursor_reg;
    assign bus.player      = player_reg;
    assign bus.busy        = busy_reg;
    assign bus.fall_active = fall_active_reg;
    assign bus.fall_row    = fall_row_reg;
    assign bus.move_done   = move_done_reg;
    assign bus.move_err    = move_err_reg;
    assign bus.last_col    = last_col_reg;
    assign bus.last_row    = last_row_reg;
endmodule

// File: tb/tb_connect4_board.sv
// Scoreboard bench for connect4_board: a game-level model predicts every
// move_done/move_err event, and a monitor compares each event as it occurs.
module tb_connect4_board;
    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam int BW   = 2*COLS*ROWS;

    logic clk;
    logic rst;

    connect4_board_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    connect4_board #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [2:0]    col;
        logic [2:0]    row;
        logic          player;
        logic [BW-1:0] board;
    } ev_t;

    ev_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int mb [ROWS][COLS];
    int mplayer;
    int mcur;
    int mlast_col;
    int mlast_row;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_flat();
        logic [BW-1:0] f;
        f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[2*(r*COLS+c) +: 2] = 2'(mb[r][c]);
        return f;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        mplayer = 0; mcur = 0; mlast_col = 0; mlast_row = 0;
    endfunction

    function automatic ev_t model_event(input logic is_err);
        ev_t e;
        e.err    = is_err;
        e.col    = 3'(mlast_col);
        e.row    = 3'(mlast_row);
        e.player = mplayer[0];
        e.board  = model_flat();
        return e;
    endfunction

    // Monitor: every committed or rejected move must have been predicted.
    always @(negedge clk) begin
        if (!rst && (bus.move_done || bus.move_err)) begin
            $display("event %s col=%0d row=%0d player=%0d",
                     bus.move_err ? "err " : "done", bus.last_col, bus.last_row, bus.player);
            if (bus.move_done && bus.move_err) check("done_and_err", 1, 0);
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_kind", bus.move_err, e.err);
                check("ev_board", bus.board, e.board);
                check("ev_player", bus.player, e.player);
                check("ev_last_col", bus.last_col, e.col);
                check("ev_last_row", bus.last_row, e.row);
            end
        end
    end

    // m: [0] tick [1] left [2] right [3] drop [4] pop, held for one cycle
    task automatic drive(input logic [4:0] m);
        @(negedge clk);
        bus.tick = m[0]; bus.btn_left = m[1]; bus.btn_right = m[2];
        bus.btn_drop = m[3]; bus.btn_pop = m[4];
        @(negedge clk);
        bus.tick = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_drop = 0; bus.btn_pop = 0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic move_cursor(input int target);
        while (mcur > target) begin drive(5'b00010); mcur--; end
        while (mcur < target) begin drive(5'b00100); mcur++; end
        check("cursor_move", bus.cursor, mcur);
    endtask

    task automatic drop_move(input logic [4:0] extra, input bit poke);
        int lr;
        int n;
        if (mb[ROWS-1][mcur] != 0) begin
            sb.push_back(model_event(1'b1));
            drive(5'b01000 | extra);
            settle();
            check("drop_err_seen", sb.size(), 0);
        end else begin
            lr = 0;
            while (mb[lr][mcur] != 0) lr++;
            mb[lr][mcur] = mplayer + 1;
            mlast_col = mcur; mlast_row = lr; mplayer ^= 1;
            sb.push_back(model_event(1'b0));
            drive(5'b01000 | extra);
            check("fall_start_row", bus.fall_row, ROWS-1);
            check("fall_start_busy", {bus.busy, bus.fall_active}, 2'b11);
            if (poke) begin
                drive(5'b00100);
                check("busy_cursor_frozen", bus.cursor, mcur);
            end
            n = 0;
            while (bus.busy && n < ROWS + 2) begin
                drive(5'b00001);
                n++;
                if (bus.busy) check("fall_row_step", bus.fall_row, ROWS-1-n);
            end
            check("fall_ticks", n, ROWS - lr);
            check("land_idle", {bus.busy, bus.fall_active}, 2'b00);
            settle();
            check("drop_done_seen", sb.size(), 0);
        end
    endtask

    task automatic pop_move();
        if (mb[0][mcur] == mplayer + 1) begin
            for (int r = 0; r < ROWS-1; r++) mb[r][mcur] = mb[r+1][mcur];
            mb[ROWS-1][mcur] = 0;
            mlast_col = mcur; mlast_row = 0; mplayer ^= 1;
            sb.push_back(model_event(1'b0));
            drive(5'b10000);
            check("pop_busy", bus.busy, 1);
            drive(5'b00001);
            check("pop_idle", bus.busy, 0);
        end else begin
            sb.push_back(model_event(1'b1));
            drive(5'b10000);
        end
        settle();
        check("pop_event_seen", sb.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.tick = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_drop = 0; bus.btn_pop = 0; bus.lock = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // reset state
        check("rst_board", bus.board, '0);
        check("rst_status", {bus.cursor, bus.player, bus.busy, bus.fall_active, bus.fall_row},
              '0);
        check("rst_last", {bus.last_col, bus.last_row, bus.move_done, bus.move_err}, '0);
        rst = 1'b0;

        // 1: cursor movement and saturation
        repeat (3) drive(5'b00100);
        drive(5'b00010);
        check("cursor_2", bus.cursor, 2);
        repeat (8) drive(5'b00100);
        check("cursor_sat_hi", bus.cursor, 6);
        mcur = 6;
        move_cursor(0);
        drive(5'b00010);
        check("cursor_sat_lo", bus.cursor, 0);

        // 2: drop on an empty column takes ROWS ticks
        move_cursor(3);
        drop_move(5'b00000, 1'b0);
        check("cell_0_3", bus.board[2*3 +: 2], 2'b01);
        check("player_after_drop", bus.player, 1);

        // 3: fill column 0, then a rejected drop
        do_reset();
        for (int i = 0; i < ROWS; i++) drop_move(5'b00000, 1'b0);
        drop_move(5'b00000, 1'b0);
        check("full_col_player", bus.player, 0);

        // 4: pop-out legal and illegal
        do_reset();
        drop_move(5'b00000, 1'b0);
        drop_move(5'b00000, 1'b0);
        drop_move(5'b00000, 1'b0);
        move_cursor(1); drop_move(5'b00000, 1'b0);
        move_cursor(2); drop_move(5'b00000, 1'b0);
        move_cursor(1); drop_move(5'b00000, 1'b0);
        move_cursor(0);
        pop_move();
        check("pop_col0", {bus.board[2*(2*COLS) +: 2], bus.board[2*COLS +: 2], bus.board[1:0]},
              6'b00_01_10);
        check("pop_player", bus.player, 1);
        move_cursor(2);
        pop_move();
        move_cursor(5);
        pop_move();

        // 5: drop beats left in the same cycle; right during FALL is ignored
        move_cursor(2);
        drop_move(5'b00010, 1'b1);
        check("drop_left_cursor", bus.cursor, 2);

        // 6: reset mid-fall aborts; lock freezes IDLE
        do_reset();
        drive(5'b01000);
        drive(5'b00001);
        drive(5'b00001);
        check("pre_abort_row", bus.fall_row, 3);
        #3 rst = 1'b1;
        #1;
        check("abort_board", bus.board, '0);
        check("abort_status", {bus.busy, bus.fall_active, bus.move_done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) drive(5'b00001);
        check("abort_no_done", bus.player, 0);

        bus.lock = 1'b1;
        drive(5'b01000);
        drive(5'b00100);
        drive(5'b00001);
        check("lock_frozen", {bus.busy, bus.cursor, bus.player}, '0);
        check("lock_board", bus.board, '0);
        bus.lock = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/connect4_board.md
Name: connect4_board

Overview:
- Game-logic core for Connect Four with the pop-out rule. It consumes one-cycle pulses from the debounced button stage: left/right move the cursor, down drops a piece, up pops a piece.
- Holds the board, the cursor, the player to move and a falling-piece animation.
- Exports the board as a flat bus for the VGA renderer and 7-segment status, plus last-move coordinates for a downstream win checker.
- Runs entirely on the 100 MHz system clock. Animation pacing comes from a one-cycle tick enable.

Parameters:
COLS, 7, board columns (at most 8)
ROWS, 6, board rows (at most 8)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tick  input  1  one-cycle enable at 10 Hz, the animation step
btn_left  input  1  one-cycle pulse, move cursor left
btn_right  input  1  one-cycle pulse, move cursor right
btn_drop  input  1  one-cycle pulse, drop piece in cursor column
btn_pop  input  1  one-cycle pulse, pop bottom piece of cursor column
lock  input  1  freezes all move input (game over)
board  output  2*COLS*ROWS  cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]; row 0 is the bottom; 00 empty, 01 P1, 10 P2
cursor  output  3  selected column
player  output  1  0 = P1 to move, 1 = P2 to move
busy  output  1  a move is in progress
fall_active  output  1  falling piece visible
fall_row  output  3  row of the falling piece (column = cursor)
move_done  output  1  one-cycle pulse, move committed
move_err  output  1  one-cycle pulse, illegal move rejected
last_col  output  3  column of the last committed move
last_row  output  3  landing row of the last drop; 0 for a pop

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE.
- States: IDLE, FALL, POP.
- IDLE with lock=0: act on inputs in priority order drop > pop > left > right. At most one action per cycle; lower-priority pulses in the same cycle are discarded.
  - left: cursor = cursor-1, saturating at 0.
  - right: cursor = cursor+1, saturating at COLS-1.
- Drop:
  - If cell (ROWS-1, cursor) is non-empty: pulse move_err the next cycle; stay IDLE.
  - Otherwise: enter FALL with fall_row=ROWS-1, fall_active=1, busy=1.
- FALL, on each cycle with tick=1:
  - If fall_row>0 and cell (fall_row-1, cursor) is empty: fall_row decrements.
  - Otherwise the piece lands. Write the player code (player+1) into (fall_row, cursor); set last_col=cursor, last_row=fall_row; toggle player; pulse move_done; clear fall_active and busy; return to IDLE. All of this happens in the same cycle.
  - Cycles with tick=0 hold state.
  - Latency from a drop on an empty column to landing is exactly ROWS ticks.
- Pop:
  - Legal only if cell (0, cursor) equals the current player's code. Otherwise pulse move_err and stay IDLE.
  - If legal: enter POP with busy=1.
  - On the next tick, shift the whole column down in one cycle: row r takes row r+1, and the top row is cleared. In that same cycle set last_col=cursor, last_row=0, toggle player, pulse move_done, clear busy, and return to IDLE.
- Cursor is frozen while busy. Every button pulse while busy is ignored with no error. lock only gates IDLE; a move in progress when lock rises completes normally.
- A tick in the same cycle a move is accepted is not counted. The first animation step uses the next tick.
- move_done and move_err never assert together. Each is high for exactly one cycle.
- rst asserted mid-FALL or mid-POP aborts the move: board cleared, no move_done.
- A full board is not detected here. Drops on full columns return move_err; pops remain legal.

Test Plan:
1. Reset, then 3 btn_right, 1 btn_left -> cursor=2. 8 more btn_right -> cursor=6 (saturates).
2. Cursor 3, btn_drop, then 6 ticks -> fall_row steps 5,4,3,2,1,0, then landing. Cell (0,3)=01, player=1, one move_done, last_row=0.
3. Six alternating drops into column 0 (P1 first), then a 7th drop -> move_err pulse; board unchanged; player unchanged.
4. Column 0 holds P1,P2,P1 from the bottom, P1 to move, btn_pop, 1 tick -> column reads P2,P1,empty. move_done pulses; player=1. Repeat the pop with P2 to move on a P1 bottom cell -> move_err.
5. btn_drop and btn_left in the same cycle -> drop taken, cursor unchanged. btn_right during FALL -> ignored, no error.
6. Assert rst while fall_row=3 -> board all zeros, fall_active=0, busy=0, no move_done. lock=1 at IDLE with btn_drop -> no state change.
